rocket_mover: RTL and testbench

ROCKET_MOVER -- requirements
Module: rocket_mover

---
 rtl/rocket_mover_if.sv | 27 ++
 rtl/rocket_mover.sv | 96 +++++++++
 tb/tb_rocket_mover.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rocket_mover_if.sv
// Link between the rockets controller (master) and one rocket_mover slot (slave).
// state_dbg mirrors the mover's FSM for checkers: 0 = IDLE, 1 = FLY, 2 = DONE.
interface rocket_mover_if;
  // Protocol: there is no valid/ready pair. startOfFrame is a one-cycle strobe. isActive is a
  // level whose rising edge launches and whose falling edge kills. initial* are sampled only on
  // the launch edge. All slave outputs are registered levels that are valid every cycle.
  logic               startOfFrame;
  logic               isActive;
  logic signed [10:0] initialSpeed;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               reachedBorder;
  logic               visible;
  logic [1:0]         state_dbg;

  modport master (
    output startOfFrame, isActive, initialSpeed, initialX, initialY,
    input  topLeftX, topLeftY, reachedBorder, visible, state_dbg
  );

  modport slave (
    input  startOfFrame, isActive, initialSpeed, initialX, initialY,
    output topLeftX, topLeftY, reachedBorder, visible, state_dbg
  );
endinterface

// File: rtl/rocket_mover.sv
// Vertical motion of one rocket: launch on isActive rise, fixed-point Y advance per frame,
// border detection with a sticky DONE state that is held until the controller kills the slot.
module rocket_mover #(
  parameter int SCREEN_TOP    = 0,
  parameter int SCREEN_BOTTOM = 479,
  parameter int ROCKET_H      = 16,
  parameter int FRAC_BITS     = 6
) (
  input  logic          clk,
  input  logic          resetN,
  rocket_mover_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The border compare runs 2 bits wider than topLeftY so adding the sprite height cannot wrap.
  localparam logic signed [12:0] TOP_S = 13'(SCREEN_TOP);
  localparam logic signed [12:0] BOT_S = 13'(SCREEN_BOTTOM);
  localparam logic signed [12:0] H_S   = 13'(ROCKET_H);

  state_t             state;
  logic               isActive_d;
  logic signed [10:0] x;
  logic signed [10:0] speed;
  logic signed [17:0] y_fp;
  logic               visible_r;
  logic               reached_r;

  logic               rise;
  logic               fall;
  logic signed [17:0] y_launch;
  logic signed [17:0] speed_ext;
  logic signed [12:0] y_ext;
  logic               out_of_range;

  assign rise = bus.isActive & ~isActive_d;
  assign fall = ~bus.isActive & isActive_d;

  assign y_launch  = {{7{bus.initialY[10]}}, bus.initialY} <<< FRAC_BITS;
  assign speed_ext = {{7{speed[10]}}, speed};

  // Integer part of the position: an arithmetic shift right by FRAC_BITS, kept to 11 bits.
  assign y_ext        = {{2{y_fp[FRAC_BITS+10]}}, y_fp[FRAC_BITS +: 11]};
  assign out_of_range = (y_ext < TOP_S) || ((y_ext + H_S) > BOT_S);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      isActive_d <= 1'b0;
      x          <= '0;
      y_fp       <= '0;
      speed      <= '0;
      visible_r  <= 1'b0;
      reached_r  <= 1'b0;
    end else begin
      isActive_d <= bus.isActive;
      if (rise) begin
        // Launch wins over a coincident frame strobe: no motion is applied this frame.
        speed     <= bus.initialSpeed;
        x         <= bus.initialX;
        y_fp      <= y_launch;
        state     <= FLY;
        visible_r <= 1'b1;
        reached_r <= 1'b0;
      end else if (fall) begin
        state     <= IDLE;
        visible_r <= 1'b0;
        reached_r <= 1'b0;
      end else begin
        case (state)
          FLY: begin
            if (out_of_range) begin
              state     <= DONE;
              visible_r <= 1'b0;
              reached_r <= 1'b1;
            end else if (bus.startOfFrame) begin
              y_fp <= y_fp + speed_ext;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.topLeftX      = x;
  assign bus.topLeftY      = y_fp[FRAC_BITS +: 11];
  assign bus.visible       = visible_r;
  assign bus.reachedBorder = reached_r;
  assign bus.state_dbg     = state;

endmodule

// File: tb/tb_rocket_mover.sv
// Directed and randomized bench for rocket_mover, checked against a launch/frame-count model.
module tb_rocket_mover;
  localparam int TOP = 0;
  localparam int BOT = 479;
  localparam int H   = 16;
  localparam int FB  = 6;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  rocket_mover_if bus();

  rocket_mover #(
    .SCREEN_TOP   (TOP),
    .SCREEN_BOTTOM(BOT),
    .ROCKET_H     (H),
    .FRAC_BITS    (FB)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  // ---------------- driven input values ----------------
  int drv_x, drv_y, drv_s;
  bit drv_act, drv_sof;

  // ---------------- reference model ----------------
  // Position is launch Y * 64 plus (frames applied) * speed; no per-bit state is tracked.
  bit m_act_d, m_fly, m_done;
  int m_x, m_y0, m_speed, m_frames;

  function automatic int model_y();
    int p;
    p = m_y0 * 64 + m_frames * m_speed;
    return (p >= 0) ? (p / 64) : -((-p + 63) / 64);
  endfunction

  function automatic logic [23:0] model_vec();
    logic [31:0] yb;
    logic [31:0] xb;
    yb = model_y();
    xb = m_x;
    return {m_fly, m_done, xb[10:0], yb[10:0]};
  endfunction

  task automatic model_reset();
    m_act_d = 0; m_fly = 0; m_done = 0;
    m_x = 0; m_y0 = 0; m_speed = 0; m_frames = 0;
  endtask

  task automatic model_edge();
    bit rise, fall;
    int y;
    rise = drv_act && !m_act_d;
    fall = !drv_act && m_act_d;
    if (rise) begin
      m_x = drv_x; m_y0 = drv_y; m_speed = drv_s; m_frames = 0;
      m_fly = 1; m_done = 0;
    end else if (fall) begin
      m_fly = 0; m_done = 0;
    end else if (m_fly) begin
      y = model_y();
      if (y < TOP || y + H > BOT) begin
        m_fly = 0; m_done = 1;
      end else if (drv_sof) begin
        m_frames++;
      end
    end
    m_act_d = drv_act;
  endtask

  // ---------------- drivers ----------------
  task automatic apply();
    logic [31:0] tx, ty, ts;
    tx = drv_x; ty = drv_y; ts = drv_s;
    bus.initialX     = tx[10:0];
    bus.initialY     = ty[10:0];
    bus.initialSpeed = ts[10:0];
    bus.isActive     = drv_act;
    bus.startOfFrame = drv_sof;
  endtask

  task automatic set_launch(input int x, input int y, input int s);
    drv_x = x; drv_y = y; drv_s = s;
    apply();
  endtask

  task automatic set_act(input bit a);
    drv_act = a;
    apply();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [23:0] exp, obs;
    exp = exp_q.pop_front();
    obs = {bus.visible, bus.reachedBorder, bus.topLeftX, bus.topLeftY};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  task automatic frame(input string tag);
    drv_sof = 1; apply();
    step(tag);
    drv_sof = 0; apply();
  endtask

  // Reset pulsed between edges; outputs must clear with no clock edge in between.
  task automatic do_reset(input string tag);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_vec());
    sb_check(tag);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drv_x = 0; drv_y = 0; drv_s = 0; drv_act = 0; drv_sof = 0;
    apply();
    model_reset();

    #1;
    exp_q.push_back(model_vec());
    sb_check("reset_outputs");
    chk("reset_state_dbg", int'(bus.state_dbg), 0);
    #11;
    resetN = 1'b1;
    step("idle0");
    step("idle1");

    // Upward launch, one frame: 400*64 - 255 = 25345, floor /64 = 396.
    set_launch(100, 400, -255);
    set_act(1);
    step("launch_up");
    chk("launch_up_vis", int'(bus.visible), 1);
    frame("up_sof1");
    chk("up_y396", int'(bus.topLeftY), 396);
    chk("up_x100", int'(bus.topLeftX), 100);
    for (int k = 0; k < 3; k++) frame("up_more");
    chk("up_x_const", int'(bus.topLeftX), 100);
    set_act(0);
    step("up_kill");

    // Downward at 1 px/frame until the bottom border.
    set_launch(50, 440, 64);
    set_act(1);
    step("down_launch");
    for (int k = 1; k <= 24; k++) begin
      frame("down_sof");
      chk("down_y_step", int'(bus.topLeftY), 440 + k);
      if (k < 24) step("down_gap");
    end
    chk("down_vis_before_done", int'(bus.visible), 1);
    step("down_done");
    chk("down_reached", int'(bus.reachedBorder), 1);
    chk("down_vis0", int'(bus.visible), 0);
    for (int k = 0; k < 3; k++) frame("done_hold");
    chk("done_y_frozen", int'(bus.topLeftY), 464);
    chk("done_reached_held", int'(bus.reachedBorder), 1);
    set_act(0);
    step("done_kill");
    chk("kill_reached0", int'(bus.reachedBorder), 0);
    chk("kill_y_hold", int'(bus.topLeftY), 464);

    // Kill coincident with a frame strobe: no motion from that frame.
    set_launch(10, 300, -64);
    set_act(1);
    step("kill_sof_launch");
    frame("kill_sof_f1");
    frame("kill_sof_f2");
    drv_act = 0; drv_sof = 1; apply();
    step("kill_with_sof");
    drv_sof = 0; apply();
    chk("kill_sof_y", int'(bus.topLeftY), 298);
    chk("kill_sof_vis", int'(bus.visible), 0);

    // Launch coincident with a frame strobe; later input changes are ignored.
    set_launch(20, 200, 128);
    drv_act = 1; drv_sof = 1; apply();
    step("rise_with_sof");
    drv_sof = 0; apply();
    chk("rise_sof_y200", int'(bus.topLeftY), 200);
    set_launch(999, 7, -100);
    step("rise_sof_gap");
    frame("rise_sof_f1");
    chk("rise_sof_y202", int'(bus.topLeftY), 202);
    chk("rise_sof_x20", int'(bus.topLeftX), 20);

    // Reset mid-flight, then relaunch because isActive is still high.
    set_act(0);
    step("pre_reset_kill");
    set_launch(30, 300, 0);
    set_act(1);
    step("pre_reset_launch");
    frame("pre_reset_f1");
    chk("pre_reset_y300", int'(bus.topLeftY), 300);
    set_launch(40, 50, 64);
    do_reset("reset_mid_flight");
    chk("reset_vis0", int'(bus.visible), 0);
    chk("reset_y0", int'(bus.topLeftY), 0);
    step("relaunch_after_reset");
    chk("relaunch_y50", int'(bus.topLeftY), 50);
    chk("relaunch_x40", int'(bus.topLeftX), 40);

    // Out-of-range launch goes to DONE one cycle after the latch.
    set_act(0);
    step("neg_kill");
    set_launch(0, -5, 64);
    set_act(1);
    step("neg_launch");
    chk("neg_y", int'(bus.topLeftY), -5);
    step("neg_done");
    chk("neg_reached", int'(bus.reachedBorder), 1);
    chk("neg_vis0", int'(bus.visible), 0);

    // Fall then rise one cycle later relaunches from new values.
    set_act(0);
    step("relaunch_fall");
    set_launch(77, 100, 32);
    set_act(1);
    step("relaunch_rise");
    chk("relaunch2_y", int'(bus.topLeftY), 100);
    chk("relaunch2_vis", int'(bus.visible), 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drv_x = int'($urandom_range(0, 2047)) - 1024;
      drv_y = int'($urandom_range(0, 540)) - 30;
      drv_s = int'($urandom_range(0, 511)) - 255;
      drv_sof = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) drv_act = !drv_act;
      apply();
      if ($urandom_range(0, 299) == 0) do_reset("rand_reset");
      else step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
